// File: rtl/sudoku_group_scanner.sv
// Walks a captured 4x4 board by rows, columns and (with SUDOKU_SCAN_SQUARES_EN) 2x2 squares,
// streaming one digit per handshake and folding each group into a presence check for board_ok.
//
// state | meaning
// IDLE  | waiting for start; board_ok holds the last verdict
// EMIT  | presenting digit of (group, cell); advances on digit_ready
// DONE  | one-cycle done pulse, verdict already latched
module sudoku_group_scanner (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] board,
    output logic        busy,
    output logic [3:0]  digit,
    output logic        digit_valid,
    input  logic        digit_ready,
    output logic [3:0]  group_id,
    output logic        group_first,
    output logic        group_last,
    output logic        done,
    output logic        board_ok
);

`ifdef SUDOKU_SCAN_SQUARES_EN
    localparam logic [3:0] LAST_GROUP = 4'd11;
`else
    localparam logic [3:0] LAST_GROUP = 4'd7;
`endif

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] board_q, board_d;
    logic [3:0]  group_q, group_d;
    logic [1:0]  cell_q, cell_d;
    logic [3:0]  mask_q, mask_d;
    logic        ok_q, ok_d;
    logic        board_ok_q, board_ok_d;

    logic [1:0]  row_sel, col_sel;
    logic [3:0]  cur_digit, digit_onehot, mask_acc;

    // Group index bits [3:2] select rows / columns / squares; [1:0] select which one.
    always_comb begin
        row_sel = group_q[1:0];
        col_sel = cell_q;
        if (group_q[3:2] == 2'd1) begin
            row_sel = cell_q;
            col_sel = group_q[1:0];
        end
`ifdef SUDOKU_SCAN_SQUARES_EN
        else if (group_q[3:2] == 2'd2) begin
            row_sel = {group_q[1], cell_q[1]};
            col_sel = {group_q[0], cell_q[0]};
        end
`endif
    end

    assign cur_digit = board_q[{row_sel, col_sel, 2'b00} +: 4];

    always_comb begin
        case (cur_digit)
            4'd1:    digit_onehot = 4'b0001;
            4'd2:    digit_onehot = 4'b0010;
            4'd3:    digit_onehot = 4'b0100;
            4'd4:    digit_onehot = 4'b1000;
            default: digit_onehot = 4'b0000;
        endcase
    end

    assign mask_acc = mask_q | digit_onehot;

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        group_d    = group_q;
        cell_d     = cell_q;
        mask_d     = mask_q;
        ok_d       = ok_q;
        board_ok_d = board_ok_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EMIT;
                    board_d = board;
                    group_d = 4'd0;
                    cell_d  = 2'd0;
                    mask_d  = 4'd0;
                    ok_d    = 1'b1;
                end
            end
            EMIT: begin
                if (digit_ready) begin
                    mask_d = mask_acc;
                    cell_d = cell_q + 2'd1;
                    if (cell_q == 2'd3) begin
                        mask_d  = 4'd0;
                        group_d = group_q + 4'd1;
                        if (mask_acc != 4'hF) ok_d = 1'b0;
                        // Latch the verdict on the final handshake so it is valid alongside done.
                        if (group_q == LAST_GROUP) begin
                            state_d    = DONE;
                            group_d    = 4'd0;
                            board_ok_d = ok_d;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            board_q    <= 64'd0;
            group_q    <= 4'd0;
            cell_q     <= 2'd0;
            mask_q     <= 4'd0;
            ok_q       <= 1'b0;
            board_ok_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            group_q    <= group_d;
            cell_q     <= cell_d;
            mask_q     <= mask_d;
            ok_q       <= ok_d;
            board_ok_q <= board_ok_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign digit_valid = (state_q == EMIT);
    assign digit       = digit_valid ? cur_digit : 4'd0;
    assign group_id    = digit_valid ? group_q : 4'd0;
    assign group_first = digit_valid && (cell_q == 2'd0);
    assign group_last  = digit_valid && (cell_q == 2'd3);
    assign done        = (state_q == DONE);
    assign board_ok    = board_ok_q;

endmodule

// File: tb/tb_sudoku_group_scanner.sv
// Randomized self-checking bench for sudoku_group_scanner against an arithmetic model of
// the group walk and per-group digit coverage; honours SUDOKU_SCAN_SQUARES_EN.
module tb_sudoku_group_scanner;

`ifdef SUDOKU_SCAN_SQUARES_EN
    localparam int NG = 12;
`else
    localparam int NG = 8;
`endif
    localparam int ND = NG * 4;

    localparam logic [63:0] VALID_BOARD = 64'h1234_3412_2143_4321;
    localparam logic [63:0] LATIN_BOARD = 64'h3214_2143_1432_4321;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] board;
    logic        busy;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        digit_ready;
    logic [3:0]  group_id;
    logic        group_first;
    logic        group_last;
    logic        done;
    logic        board_ok;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_ok = 1'b0;

    always #5 clk = ~clk;

    sudoku_group_scanner dut (
        .clk(clk), .rst(rst), .start(start), .board(board), .busy(busy),
        .digit(digit), .digit_valid(digit_valid), .digit_ready(digit_ready),
        .group_id(group_id), .group_first(group_first), .group_last(group_last),
        .done(done), .board_ok(board_ok)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_digit(input logic [63:0] b, input int g, input int k);
        int r, c, s;
        if (g < 4) begin
            r = g; c = k;
        end else if (g < 8) begin
            r = k; c = g - 4;
        end else begin
            s = g - 8;
            r = 2 * (s / 2) + k / 2;
            c = 2 * (s % 2) + k % 2;
        end
        return 4'((b >> (4 * (4 * r + c))) & 64'hF);
    endfunction

    function automatic logic ref_ok(input logic [63:0] b);
        logic ok;
        logic seen [5];
        int   d;
        ok = 1'b1;
        for (int g = 0; g < NG; g++) begin
            for (int i = 0; i < 5; i++) seen[i] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                d = int'(ref_digit(b, g, k));
                if (d >= 1 && d <= 4) seen[d] = 1'b1;
            end
            if (!(seen[1] && seen[2] && seen[3] && seen[4])) ok = 1'b0;
        end
        return ok;
    endfunction

    // Relabelling digits 1..4 by a random permutation keeps a valid board valid.
    function automatic logic [63:0] relabel(input logic [63:0] b);
        logic [3:0]  p [4];
        logic [3:0]  t, nib;
        logic [63:0] res;
        int j;
        for (int i = 0; i < 4; i++) p[i] = 4'(i + 1);
        for (int i = 3; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
        res = b;
        for (int i = 0; i < 16; i++) begin
            nib = b[4*i +: 4];
            if (nib >= 4'd1 && nib <= 4'd4) res[4*i +: 4] = p[int'(nib) - 1];
        end
        return res;
    endfunction

    // mode: 0 ready always high, 1 ready high on even cycles only, 2 random ready.
    task automatic run_scan(input logic [63:0] b, input int mode, input int glitch_cyc,
                            input int rst_cyc, input int exp_done_cyc);
        int   idx, stalls;
        logic finished, rdy, exp_ok;
        exp_ok = ref_ok(b);
        @(negedge clk);
        board = b; start = 1'b1; digit_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        idx = 0; stalls = 0; finished = 1'b0;
        for (int cyc = 1; cyc < 400 && !finished; cyc++) begin
            if (cyc == rst_cyc) begin
                rst = 1'b1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_digit", digit, 0);
                check("rst_valid", digit_valid, 0);
                check("rst_group", group_id, 0);
                check("rst_first", group_first, 0);
                check("rst_last", group_last, 0);
                check("rst_done", done, 0);
                check("rst_ok", board_ok, 0);
                @(negedge clk);
                rst = 1'b0;
                prev_ok = 1'b0;
                for (int w = 0; w < 3; w++) begin
                    @(negedge clk);
                    check("post_rst_done", done, 0);
                    check("post_rst_busy", busy, 0);
                end
                finished = 1'b1;
            end else if (done) begin
                if (exp_done_cyc > 0) check("done_cycle", cyc, exp_done_cyc);
                check("done_cycle_stalls", cyc, ND + stalls + 1);
                check("digit_count", idx, ND);
                check("board_ok", board_ok, exp_ok);
                check("done_valid", digit_valid, 0);
                check("done_busy", busy, 1);
                prev_ok = exp_ok;
                finished = 1'b1;
                @(negedge clk);
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                check("idle_ok_hold", board_ok, exp_ok);
            end else begin
                check("emit_busy", busy, 1);
                check("emit_ok_hold", board_ok, prev_ok);
                check("emit_valid", digit_valid, 1);
                if (idx < ND) begin
                    check("digit", digit, ref_digit(b, idx / 4, idx % 4));
                    check("group_id", group_id, 64'(idx / 4));
                    check("group_first", group_first, (idx % 4) == 0);
                    check("group_last", group_last, (idx % 4) == 3);
                end else begin
                    check("extra_digit", idx, ND - 1);
                end
                start = (cyc == glitch_cyc);
                if (cyc == glitch_cyc) board = {$urandom, $urandom};
                if (mode == 0)      rdy = 1'b1;
                else if (mode == 1) rdy = (cyc % 2 == 0);
                else                rdy = 1'($urandom_range(0, 1));
                digit_ready = rdy;
                if (rdy) idx++;
                else     stalls++;
                @(negedge clk);
            end
        end
        if (!finished) check("scan_timeout", 1, 0);
        start = 1'b0;
        digit_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] b;
        rst = 1'b1; start = 1'b0; digit_ready = 1'b0; board = 64'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_digit", digit, 0);
        check("reset_valid", digit_valid, 0);
        check("reset_group", group_id, 0);
        check("reset_first", group_first, 0);
        check("reset_last", group_last, 0);
        check("reset_done", done, 0);
        check("reset_ok", board_ok, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start", busy, 0);

        run_scan(VALID_BOARD, 0, -1, -1, ND + 1);
        check("valid_verdict", board_ok, 1);

        run_scan(LATIN_BOARD, 0, -1, -1, ND + 1);
        check("latin_verdict", board_ok, (NG == 8) ? 1 : 0);

        run_scan(VALID_BOARD, 1, -1, -1, 2 * ND + 1);
        check("toggle_verdict", board_ok, 1);

        run_scan(VALID_BOARD & ~(64'hF << 24), 0, -1, -1, ND + 1);
        check("hole_verdict", board_ok, 0);

        run_scan(VALID_BOARD, 0, 10, -1, ND + 1);
        run_scan(VALID_BOARD, 0, 10, 20, 0);
        run_scan(relabel(VALID_BOARD), 0, -1, -1, ND + 1);
        check("after_rst_verdict", board_ok, 1);

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) b = relabel(VALID_BOARD);
            else            b = {$urandom, $urandom} & 64'h3333_3333_3333_3333;
            run_scan(b, 2, -1, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
